// File: rtl/cpu_execution_unit.sv
// 16-bit RISC datapath: PC, IR, 8x16 register file, ALU and memory bus drive.
// Build option EU_R0_ZERO_EN hardwires R0 to zero (writes dropped, reads return 0).
module cpu_execution_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  W_Adr,
   input  logic [2:0]  R_Adr,
   input  logic [2:0]  S_Adr,
   input  logic        adr_sel,
   input  logic        s_sel,
   input  logic        pc_ld,
   input  logic        pc_inc,
   input  logic        pc_sel,
   input  logic        ir_ld,
   input  logic        rw_en,
   input  logic [3:0]  alu_op,
   input  logic [15:0] D_in,
   output logic [15:0] Address,
   output logic [15:0] D_out,
   output logic [15:0] IR,
   output logic        N,
   output logic        Z,
   output logic        C
);

   localparam logic [3:0] OP_PASS_S = 4'b0000;
   localparam logic [3:0] OP_PASS_R = 4'b0001;
   localparam logic [3:0] OP_INC    = 4'b0010;
   localparam logic [3:0] OP_DEC    = 4'b0011;
   localparam logic [3:0] OP_ADD    = 4'b0100;
   localparam logic [3:0] OP_SUB    = 4'b0101;
   localparam logic [3:0] OP_SHR    = 4'b0110;
   localparam logic [3:0] OP_SHL    = 4'b0111;
   localparam logic [3:0] OP_AND    = 4'b1000;
   localparam logic [3:0] OP_OR     = 4'b1001;
   localparam logic [3:0] OP_XOR    = 4'b1010;
   localparam logic [3:0] OP_NOT    = 4'b1011;
   localparam logic [3:0] OP_NEG    = 4'b1100;

   logic [15:0] regs_q [8];
   logic [15:0] pc_q, pc_d;
   logic [15:0] ir_q, ir_d;

   logic [15:0] r_data;
   logic [15:0] s_data;
   logic [15:0] alu_res;
   logic        alu_c;
   logic [16:0] wide;
   logic [15:0] wr_data;
   logic        wr_en;

`ifdef EU_R0_ZERO_EN
   assign r_data = (R_Adr == 3'd0) ? 16'h0000 : regs_q[R_Adr];
   assign s_data = (S_Adr == 3'd0) ? 16'h0000 : regs_q[S_Adr];
   assign wr_en  = rw_en && (W_Adr != 3'd0);
`else
   assign r_data = regs_q[R_Adr];
   assign s_data = regs_q[S_Adr];
   assign wr_en  = rw_en;
`endif

   // Carry/borrow come from bit 16 of a zero-extended 17-bit operation.
   always_comb begin
      alu_res = s_data;
      alu_c   = 1'b0;
      wide    = 17'd0;
      case (alu_op)
         OP_PASS_S: alu_res = s_data;
         OP_PASS_R: alu_res = r_data;
         OP_INC: begin
            wide    = {1'b0, s_data} + 17'd1;
            alu_res = wide[15:0];
            alu_c   = wide[16];
         end
         OP_DEC: begin
            wide    = {1'b0, s_data} - 17'd1;
            alu_res = wide[15:0];
            alu_c   = wide[16];
         end
         OP_ADD: begin
            wide    = {1'b0, r_data} + {1'b0, s_data};
            alu_res = wide[15:0];
            alu_c   = wide[16];
         end
         OP_SUB: begin
            wide    = {1'b0, r_data} - {1'b0, s_data};
            alu_res = wide[15:0];
            alu_c   = wide[16];
         end
         OP_SHR: begin
            alu_res = {1'b0, s_data[15:1]};
            alu_c   = s_data[0];
         end
         OP_SHL: begin
            alu_res = {s_data[14:0], 1'b0};
            alu_c   = s_data[15];
         end
         OP_AND:  alu_res = r_data & s_data;
         OP_OR:   alu_res = r_data | s_data;
         OP_XOR:  alu_res = r_data ^ s_data;
         OP_NOT:  alu_res = ~s_data;
         OP_NEG: begin
            wide    = 17'd0 - {1'b0, s_data};
            alu_res = wide[15:0];
            alu_c   = wide[16];
         end
         default: alu_res = s_data;
      endcase
   end

   assign N = alu_res[15];
   assign Z = (alu_res == 16'h0000);
   assign C = alu_c;

   assign wr_data = s_sel ? D_in : alu_res;

   always_comb begin
      pc_d = pc_q;
      if (pc_ld) begin
         pc_d = pc_sel ? s_data : pc_q + {{8{ir_q[7]}}, ir_q[7:0]};
      end else if (pc_inc) begin
         pc_d = pc_q + 16'd1;
      end
   end

   assign ir_d = ir_ld ? D_in : ir_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q <= RESET_PC;
         ir_q <= 16'h0000;
         for (int i = 0; i < 8; i++) begin
            regs_q[i] <= 16'h0000;
         end
      end else begin
         pc_q <= pc_d;
         ir_q <= ir_d;
         if (wr_en) begin
            regs_q[W_Adr] <= wr_data;
         end
      end
   end

   assign Address = adr_sel ? r_data : pc_q;
   assign D_out   = s_data;
   assign IR      = ir_q;

endmodule

// File: tb/tb_cpu_execution_unit.sv
// Directed bench for cpu_execution_unit: fetch, ALU flags, branches, addressing, R0 and reset.
module tb_cpu_execution_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  W_Adr, R_Adr, S_Adr;
   logic        adr_sel, s_sel, pc_ld, pc_inc, pc_sel, ir_ld, rw_en;
   logic [3:0]  alu_op;
   logic [15:0] D_in;
   logic [15:0] Address, D_out, IR;
   logic        N, Z, C;

   int checks = 0;
   int passed = 0;

   cpu_execution_unit #(.RESET_PC(16'h0000)) dut (
      .clk(clk), .reset(reset),
      .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr),
      .adr_sel(adr_sel), .s_sel(s_sel), .pc_ld(pc_ld), .pc_inc(pc_inc),
      .pc_sel(pc_sel), .ir_ld(ir_ld), .rw_en(rw_en), .alu_op(alu_op),
      .D_in(D_in), .Address(Address), .D_out(D_out), .IR(IR),
      .N(N), .Z(Z), .C(C)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pc_ld = 0; pc_inc = 0; pc_sel = 0; ir_ld = 0; rw_en = 0;
      s_sel = 0; adr_sel = 0;
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [15:0] v);
      s_sel = 1; rw_en = 1; W_Adr = a; D_in = v;
      tick();
      rw_en = 0; s_sel = 0;
   endtask

   task automatic rd_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
      adr_sel = 1; R_Adr = a;
      #1;
      chk(tag, Address, exp);
      adr_sel = 0;
   endtask

   task automatic flags(input string tag, input logic [2:0] exp_nzc);
      #1;
      chk(tag, {13'd0, N, Z, C}, {13'd0, exp_nzc});
   endtask

   initial begin
      reset = 0;
      idle();
      W_Adr = 0; R_Adr = 0; S_Adr = 0; alu_op = 4'b0000; D_in = 16'h0000;
      #2;
      chk("reset_addr", Address, 16'h0000);
      chk("reset_dout", D_out, 16'h0000);
      chk("reset_ir", IR, 16'h0000);
      flags("reset_flags", 3'b010);
      tick(); tick();
      reset = 1;

      // fetch
      ir_ld = 1; pc_inc = 1; D_in = 16'hE0CA;
      tick();
      idle();
      chk("fetch_ir", IR, 16'hE0CA);
      chk("fetch_pc", Address, 16'h0001);

      // ADD with carry out to zero
      wr_reg(3'd1, 16'hFFFF);
      wr_reg(3'd2, 16'h0001);
      alu_op = 4'b0100; R_Adr = 1; S_Adr = 2; W_Adr = 3; s_sel = 0; rw_en = 1;
      flags("add_flags", 3'b011);
      tick();
      rw_en = 0;
      rd_reg("add_r3", 3'd3, 16'h0000);

      // SUB with and without borrow
      wr_reg(3'd1, 16'h0003);
      wr_reg(3'd2, 16'h0005);
      alu_op = 4'b0101; R_Adr = 1; S_Adr = 2; W_Adr = 3; rw_en = 1;
      flags("sub_borrow_flags", 3'b101);
      tick();
      rw_en = 0;
      rd_reg("sub_borrow_res", 3'd3, 16'hFFFE);
      wr_reg(3'd1, 16'h0005);
      wr_reg(3'd2, 16'h0003);
      alu_op = 4'b0101; R_Adr = 1; S_Adr = 2; W_Adr = 3; rw_en = 1;
      flags("sub_nb_flags", 3'b000);
      tick();
      rw_en = 0;
      rd_reg("sub_nb_res", 3'd3, 16'h0002);

      // shifts, negate, inc/dec, xor on S = 0x8001
      wr_reg(3'd2, 16'h8001);
      S_Adr = 2; R_Adr = 2;
      alu_op = 4'b0110; flags("shr_flags", 3'b001);
      alu_op = 4'b0111; flags("shl_flags", 3'b001);
      alu_op = 4'b1100; flags("neg_flags", 3'b001);
      alu_op = 4'b1010; flags("xor_flags", 3'b010);
      alu_op = 4'b1011; flags("not_flags", 3'b000);
      wr_reg(3'd2, 16'hFFFF);
      alu_op = 4'b0010; flags("inc_wrap_flags", 3'b011);
      wr_reg(3'd2, 16'h0000);
      alu_op = 4'b0011; flags("dec_wrap_flags", 3'b101);
      alu_op = 4'b1100; flags("neg_zero_flags", 3'b010);
      alu_op = 4'b0000;

      // relative branch wrapping below zero, then load beats increment
      ir_ld = 1; D_in = 16'h00FC;
      tick();
      ir_ld = 0;
      chk("pc_before_br", Address, 16'h0001);
      pc_ld = 1; pc_sel = 0;
      tick();
      idle();
      chk("br_wrap_pc", Address, 16'hFFFD);
      wr_reg(3'd5, 16'h0040);
      S_Adr = 5; pc_ld = 1; pc_inc = 1; pc_sel = 1;
      tick();
      idle();
      chk("jmp_pc", Address, 16'h0040);
      pc_inc = 1;
      tick();
      idle();
      chk("inc_pc", Address, 16'h0041);

      // LD/STO addressing and D_in write-back
      wr_reg(3'd4, 16'h1234);
      wr_reg(3'd5, 16'hBEEF);
      adr_sel = 1; R_Adr = 4; S_Adr = 5;
      #1;
      chk("ld_addr", Address, 16'h1234);
      chk("sto_dout", D_out, 16'hBEEF);
      adr_sel = 0;
      wr_reg(3'd6, 16'h00AA);
      rd_reg("ld_r6", 3'd6, 16'h00AA);

      // same-cycle write/read returns the old value
      adr_sel = 1; R_Adr = 6; s_sel = 1; rw_en = 1; W_Adr = 6; D_in = 16'h1111;
      #1;
      chk("wr_rd_old", Address, 16'h00AA);
      tick();
      rw_en = 0; s_sel = 0;
      #1;
      chk("wr_rd_new", Address, 16'h1111);
      adr_sel = 0;

      // R0 behaviour depends on build option
      wr_reg(3'd0, 16'h5555);
`ifdef EU_R0_ZERO_EN
      rd_reg("r0_read", 3'd0, 16'h0000);
      S_Adr = 0; #1; chk("r0_sport", D_out, 16'h0000);
`else
      rd_reg("r0_read", 3'd0, 16'h5555);
      S_Adr = 0; #1; chk("r0_sport", D_out, 16'h5555);
`endif

      // async reset in the middle of a write to R7
      s_sel = 1; rw_en = 1; W_Adr = 7; D_in = 16'h7777; adr_sel = 0;
      #2;
      reset = 0;
      #1;
      chk("rst_pc_now", Address, 16'h0000);
      chk("rst_ir_now", IR, 16'h0000);
      tick();
      reset = 1;
      rw_en = 0; s_sel = 0;
      rd_reg("rst_r7", 3'd7, 16'h0000);
      S_Adr = 6; #1; chk("rst_r6", D_out, 16'h0000);
      chk("rst_pc_hold", Address, 16'h0000);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
